// File: rtl/ram_pkg.sv
// Shared FSM encoding and default width constants for the RAM stream reader.
package ram_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 4;
    localparam int unsigned DEPTH      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_addr_gen.sv
// Address and remaining-word counters for a RAM read burst; the address wraps at depth-1.
module ram_addr_gen
    import ram_pkg::*;
#(
    parameter int unsigned addr_width = ADDR_WIDTH,
    parameter int unsigned depth      = DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  advance,
    input  logic [addr_width-1:0] start_addr,
    input  logic [addr_width:0]   length,
    output logic [addr_width-1:0] addr,
    output logic [addr_width:0]   remaining,
    output logic                  last_c
);

    localparam int unsigned CNT_W = addr_width + 1;

    assign last_c = (remaining == CNT_W'(1));

    // The final fetch leaves the address in place so ram_addr holds the last word read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= start_addr;
            remaining <= length;
        end else if (advance) begin
            remaining <= remaining - CNT_W'(1);
            if (!last_c) begin
                if (addr == addr_width'(depth - 1)) begin
                    addr <= '0;
                end else begin
                    addr <= addr + addr_width'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a burst of RAM words out on a valid/ready interface.
// Optional abort input enabled by defining RAM_STREAM_READER_ABORT_EN.
module ram_stream_reader
    import ram_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH,
    parameter int unsigned addr_width = ADDR_WIDTH,
    parameter int unsigned depth      = DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef RAM_STREAM_READER_ABORT_EN
    input  logic                  abort,
`endif
    input  logic [addr_width-1:0] start_addr,
    input  logic [addr_width:0]   length,
    output logic [addr_width-1:0] ram_addr,
    output logic                  ram_en,
    input  logic [data_width-1:0] ram_data,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    state_t                state_q;
    state_t                state_d;
    logic                  abort_c;
    logic                  fire_c;
    logic                  hs_c;
    logic                  load_c;
    logic                  advance_c;
    logic                  last_c;
    logic [addr_width:0]   remaining;

`ifdef RAM_STREAM_READER_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    ram_addr_gen #(
        .addr_width (addr_width),
        .depth      (depth)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_c),
        .advance    (advance_c),
        .start_addr (start_addr),
        .length     (length),
        .addr       (ram_addr),
        .remaining  (remaining),
        .last_c     (last_c)
    );

    // Next-state and counter control
    always_comb begin
        state_d   = state_q;
        fire_c    = (state_q == ST_READ) && (!m_valid || m_ready);
        hs_c      = m_valid && m_ready;
        load_c    = 1'b0;
        advance_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (length != '0)) begin
                    load_c  = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (abort_c) begin
                    state_d = ST_IDLE;
                end else if (fire_c) begin
                    advance_c = 1'b1;
                    if (last_c) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort_c || hs_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered stream outputs and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            ram_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done   <= 1'b0;
            ram_en <= (state_d == ST_READ);
            busy   <= (state_d != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (start && (length == '0)) begin
                        done <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (abort_c) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        done    <= 1'b1;
                    end else if (fire_c) begin
                        m_data  <= ram_data;
                        m_valid <= 1'b1;
                        m_last  <= last_c;
                    end
                end
                ST_DRAIN: begin
                    if (abort_c || hs_c) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter data_width, default 8, meaning the RAM word width in bits.
REQ-002 SHALL have parameter addr_width, default 4, meaning the RAM address width.
REQ-003 SHALL have parameter depth, default 16, meaning the number of RAM words (at most 2**addr_width).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  command strobe, sampled only in IDLE.
REQ-007 SHALL have port start_addr  input  addr_width  first RAM address of the burst.
REQ-008 SHALL have port length  input  addr_width+1  words to read, 0..depth.
REQ-009 SHALL have port ram_addr  output  addr_width  drives the RAM read-port address.
REQ-010 SHALL have port ram_en  output  1  drives the RAM read-port enable.
REQ-011 SHALL have port ram_data  input  data_width  RAM read data, combinational from ram_addr.
REQ-012 SHALL have port m_data  output  data_width  stream data.
REQ-013 SHALL have port m_valid  output  1  stream data valid.
REQ-014 SHALL have port m_ready  input  1  downstream accepts data.
REQ-015 SHALL have port m_last  output  1  marks the final word of the burst.
REQ-016 SHALL have port busy  output  1  high in READ or DRAIN.
REQ-017 SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-018 SHALL implement FSM states IDLE, READ and DRAIN.
REQ-019 IDLE: start=1 with length>0 SHALL load the address counter with start_addr and the remaining counter with length, then move to READ.
REQ-020 IDLE: start=1 with length=0 SHALL stay in IDLE and pulse done on the next cycle, with no m_valid.
REQ-021 READ: ram_en SHALL be 1, and ram_addr SHALL equal the address counter.
REQ-022 READ: when m_valid=0 or m_ready=1, ram_data SHALL be captured into m_data on the clock edge, with m_valid=1; the address counter SHALL then increment and the remaining counter SHALL decrement.
REQ-023 Latency SHALL be 2 cycles from the start edge to m_valid=1, with sustained throughput of one word per cycle while m_ready=1.
REQ-024 m_data, m_valid and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-025 The address SHALL wrap from depth-1 to 0.
REQ-026 m_last SHALL be 1 exactly with the word fetched when the remaining count is 1; the FSM SHALL then enter DRAIN, with ram_en=0.
REQ-027 DRAIN: on the m_valid&m_ready handshake, m_valid SHALL clear, done SHALL pulse in that same cycle, and the FSM SHALL return to IDLE.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 ram_en SHALL be 0 outside READ, and ram_addr SHALL hold its last value.

Reset
REQ-030 rst_n=0 SHALL force, at any time including mid-burst, IDLE, m_valid=0, m_last=0, m_data=0, ram_en=0, ram_addr=0, busy=0, done=0, and both counters to 0; any in-flight word SHALL be discarded.

Configuration
REQ-031 With RAM_STREAM_READER_ABORT_EN defined, the block SHALL have an extra input abort; abort=1 in READ or DRAIN SHALL clear m_valid and m_last and return to IDLE at the next edge, with done pulsed.
REQ-032 Without RAM_STREAM_READER_ABORT_EN, the abort port SHALL be absent and a burst SHALL end only by completion or reset.

Structure
REQ-033 The FSM state encodings and the default width constants SHALL live in shared package ram_pkg.
REQ-034 Address and remaining-count generation SHALL be a sub-module named ram_addr_gen; the FSM and the output register SHALL stay in the top module.

Verification
REQ-035 The bench SHALL cover: RAM preloaded with data=addr+8'h10, start_addr=2, length=4, m_ready=1 -> m_data 12,13,14,15 on consecutive cycles, m_last with 15, done one cycle after the last handshake is possible.
REQ-036 The bench SHALL cover: start_addr=14, length=4, depth=16 -> address sequence 14,15,0,1 with data 1E,1F,10,11.
REQ-037 The bench SHALL cover: length=3 with m_ready toggling 1,0,0,1,... -> no word lost or duplicated, m_data stable while stalled, done after the third handshake.
REQ-038 The bench SHALL cover: start with length=0 -> done pulse, m_valid never 1; start during busy -> ignored, burst unchanged.
REQ-039 The bench SHALL cover: rst_n=0 after 2 of 8 words -> all outputs reach reset values asynchronously; a new start after release streams correctly from its start_addr.
REQ-040 The bench SHALL cover, with RAM_STREAM_READER_ABORT_EN: abort after the first handshake of length=6 -> m_valid=0 next cycle, done pulse, state IDLE.
